llc_ctrl: RTL and testbench

- Sequencing controller for the last-level cache tag/state store (N_WAY-way set-associative, MESI, tree-PLRU per set).
- Accepts one CPU or snoop request at a time over a valid/ready handshake and performs the tag lookup.
- Updates MESI state and PLRU bits, and selects a victim on a miss.
- Issues bus operations (fill, RWIM, invalidate, writeback) over a request/ack handshake. Sits between the CPU-side request stream and the bus/memory model.

---
 rtl/llc_ctrl_pkg.sv | 53 +++++
 rtl/llc_ctrl_plru.sv | 33 +++
 rtl/llc_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_llc_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_ctrl_pkg.sv
// rtl/llc_ctrl_pkg.sv - shared constants, types and helpers for the LLC tag/state controller
package llc_ctrl_pkg;

  localparam int ADDR_SIZE   = 32;
  localparam int OFFSET_SIZE = 6;
  localparam int INDEX_SIZE  = 14;
  localparam int N_WAY       = 16;
  localparam int WAY_W       = $clog2(N_WAY);
  localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int NUM_SETS    = 2 ** INDEX_SIZE;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    CMD_CPU_RD  = 2'd0,
    CMD_CPU_WR  = 2'd1,
    CMD_SNP_RD  = 2'd2,
    CMD_SNP_INV = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    BUS_READ      = 2'd0,
    BUS_RWIM      = 2'd1,
    BUS_INVAL     = 2'd2,
    BUS_WRITEBACK = 2'd3
  } bus_op_e;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_SIZE-1:0] tag;
    mesi_e               mesi;
  } line_st;

  typedef struct packed {
    logic [N_WAY-2:0]   plru_bits;
    line_st [N_WAY-1:0] ways;
  } set_st;

  localparam line_st LINE_RESET = '{valid: 1'b0, dirty: 1'b0, tag: '0, mesi: MESI_I};

  // Line-aligned bus address built from a tag and set index.
  function automatic logic [ADDR_SIZE-1:0] line_addr(input logic [TAG_SIZE-1:0]   tag,
                                                     input logic [INDEX_SIZE-1:0] index);
    return {tag, index, {OFFSET_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_ctrl_plru.sv
// rtl/llc_ctrl_plru.sv - tree-PLRU victim walk and access update for one set
module plru_tree
  import llc_ctrl_pkg::*;
(
  input  logic [N_WAY-2:0] plru_bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim_way,
  output logic [N_WAY-2:0] plru_next
);

  // Heap-ordered tree: node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
  always_comb begin
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way_sh;
    logic             dir;
    victim_way = '0;
    node       = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way = (victim_way << 1) | WAY_W'(plru_bits[node]);
      node       = (node << 1) + WAY_W'(1) + WAY_W'(plru_bits[node]);
    end
    plru_next = plru_bits;
    node      = '0;
    way_sh    = access_way;
    for (int l = 0; l < WAY_W; l++) begin
      dir             = way_sh[WAY_W-1];
      plru_next[node] = ~dir;
      node            = (node << 1) + WAY_W'(1) + WAY_W'(dir);
      way_sh          = way_sh << 1;
    end
  end

endmodule

// File: rtl/llc_ctrl.sv
// rtl/llc_ctrl.sv - LLC tag/MESI/PLRU sequencing controller with bus handshake
module llc_ctrl
  import llc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [ADDR_SIZE-1:0] req_addr,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic [1:0]           resp_mesi,
  output logic                 bus_valid,
  output logic [1:0]           bus_op,
  output logic [ADDR_SIZE-1:0] bus_addr,
  input  logic                 bus_ack,
  input  logic                 bus_shared
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_BUS_WB, ST_BUS_OP, ST_RESP
  } state_e;

  state_e state, state_next;

  set_st sets [NUM_SETS];

  cmd_e                  cmd_q;
  logic [TAG_SIZE-1:0]   tag_q;
  logic [INDEX_SIZE-1:0] idx_q;
  logic                  hit_q;
  logic [WAY_W-1:0]      way_q;
  mesi_e                 mesi_q;
  logic                  op_pend_q;
  bus_op_e               op_q;
  logic [ADDR_SIZE-1:0]  wb_addr_q;

  set_st               cur_set;
  logic                hit_any, inv_any;
  logic [WAY_W-1:0]    hit_way, inv_way, lk_way, plru_victim;
  logic [N_WAY-2:0]    plru_next;
  mesi_e               lk_mesi;
  logic                lk_dirty;
  logic [TAG_SIZE-1:0] lk_tag;
  logic                is_cpu;
  logic                plan_wb, plan_op;
  bus_op_e             plan_bus;
  mesi_e               plan_mesi;

  assign cur_set = sets[idx_q];
  assign is_cpu  = (cmd_q == CMD_CPU_RD) || (cmd_q == CMD_CPU_WR);

  plru_tree u_plru (
    .plru_bits (cur_set.plru_bits),
    .access_way(way_q),
    .victim_way(plru_victim),
    .plru_next (plru_next)
  );

  // Tag compare and victim choice: lowest invalid way first, else the PLRU walk.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (cur_set.ways[w].valid && cur_set.ways[w].tag == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (!cur_set.ways[w].valid) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    lk_way   = hit_any ? hit_way : (inv_any ? inv_way : plru_victim);
    lk_mesi  = cur_set.ways[lk_way].mesi;
    lk_dirty = cur_set.ways[lk_way].dirty;
    lk_tag   = cur_set.ways[lk_way].tag;
  end

  // Decide bus work and resulting MESI state from the lookup outcome.
  always_comb begin
    plan_wb   = 1'b0;
    plan_op   = 1'b0;
    plan_bus  = BUS_READ;
    plan_mesi = lk_mesi;
    case (cmd_q)
      CMD_CPU_RD: begin
        if (!hit_any) begin
          plan_wb   = lk_dirty;
          plan_op   = 1'b1;
          plan_bus  = BUS_READ;
          plan_mesi = MESI_E;
        end
      end
      CMD_CPU_WR: begin
        plan_mesi = MESI_M;
        if (hit_any) begin
          if (lk_mesi == MESI_S) begin
            plan_op  = 1'b1;
            plan_bus = BUS_INVAL;
          end
        end else begin
          plan_wb  = lk_dirty;
          plan_op  = 1'b1;
          plan_bus = BUS_RWIM;
        end
      end
      CMD_SNP_RD: begin
        plan_wb   = hit_any && lk_dirty;
        plan_mesi = hit_any ? MESI_S : MESI_I;
      end
      CMD_SNP_INV: begin
        plan_wb   = hit_any && lk_dirty;
        plan_mesi = MESI_I;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state and handshake outputs; everything is forced quiet while in reset.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_way   = '0;
    resp_mesi  = 2'd0;
    bus_valid  = 1'b0;
    bus_op     = 2'd0;
    bus_addr   = '0;
    case (state)
      ST_IDLE: begin
        req_ready = rst;
        if (req_valid) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (plan_wb)      state_next = ST_BUS_WB;
        else if (plan_op) state_next = ST_BUS_OP;
        else              state_next = ST_RESP;
      end
      ST_BUS_WB: begin
        bus_valid = rst;
        bus_op    = rst ? BUS_WRITEBACK : 2'd0;
        bus_addr  = rst ? wb_addr_q : '0;
        if (bus_ack) state_next = op_pend_q ? ST_BUS_OP : ST_RESP;
      end
      ST_BUS_OP: begin
        bus_valid = rst;
        bus_op    = rst ? op_q : 2'd0;
        bus_addr  = rst ? line_addr(tag_q, idx_q) : '0;
        if (bus_ack) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = rst;
        resp_hit   = rst && hit_q;
        resp_way   = rst ? way_q : '0;
        resp_mesi  = rst ? mesi_q : 2'd0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, lookup results and the single commit of line/PLRU state in RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q     <= CMD_CPU_RD;
      tag_q     <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      way_q     <= '0;
      mesi_q    <= MESI_I;
      op_pend_q <= 1'b0;
      op_q      <= BUS_READ;
      wb_addr_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        sets[s].plru_bits <= '0;
        for (int w = 0; w < N_WAY; w++) sets[s].ways[w] <= LINE_RESET;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q <= cmd_e'(req_cmd);
            tag_q <= req_addr[ADDR_SIZE-1:OFFSET_SIZE+INDEX_SIZE];
            idx_q <= req_addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
          end
        end
        ST_LOOKUP: begin
          hit_q     <= hit_any;
          way_q     <= (!hit_any && !is_cpu) ? '0 : lk_way;
          mesi_q    <= plan_mesi;
          op_pend_q <= plan_op;
          op_q      <= plan_bus;
          wb_addr_q <= line_addr(lk_tag, idx_q);
        end
        ST_BUS_OP: begin
          if (bus_ack && op_q == BUS_READ) mesi_q <= bus_shared ? MESI_S : MESI_E;
        end
        ST_RESP: begin
          if (is_cpu || hit_q) begin
            sets[idx_q].ways[way_q] <= '{valid: (mesi_q != MESI_I), dirty: (mesi_q == MESI_M),
                                         tag: tag_q, mesi: mesi_q};
          end
          if (is_cpu) sets[idx_q].plru_bits <= plru_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_ctrl.sv
// tb/tb_llc_ctrl.sv - self-checking bench for llc_ctrl against a recency-based cache model
module tb_llc_ctrl;

  localparam int ST_M = 0, ST_E = 1, ST_S = 2, ST_I = 3;
  localparam logic [1:0] C_RD = 2'd0, C_WR = 2'd1, C_SRD = 2'd2, C_SINV = 2'd3;
  localparam logic [1:0] OP_READ = 2'd0, OP_RWIM = 2'd1, OP_INVAL = 2'd2, OP_WB = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'd0;
  logic [31:0] req_addr = '0;
  logic        resp_valid, resp_hit;
  logic [3:0]  resp_way;
  logic [1:0]  resp_mesi;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic        bus_shared = 1'b0;

  always #5 clk = ~clk;

  llc_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_mesi(resp_mesi),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_shared(bus_shared)
  );

  int checks = 0;
  int errors = 0;

  // Model: per line state/tag, and the time of the last CPU access to each way.
  int          m_mesi [8][16];
  logic [11:0] m_tag  [8][16];
  int          m_time [8][16];
  int          now_t;

  logic [1:0]  e_op[$];
  logic [31:0] e_addr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 16; w++) begin
        m_mesi[s][w] = ST_I;
        m_tag[s][w]  = '0;
        m_time[s][w] = 0;
      end
    now_t = 0;
  endfunction

  function automatic int max_time(int s, int lo, int n);
    int m = 0;
    for (int w = lo; w < lo + n; w++) if (m_time[s][w] > m) m = m_time[s][w];
    return m;
  endfunction

  // Pseudo-LRU by definition: at every subtree split, go toward the half touched less recently.
  function automatic int model_victim(int s);
    int lo = 0;
    int size = 16;
    for (int w = 0; w < 16; w++) if (m_mesi[s][w] == ST_I) return w;
    while (size > 1) begin
      if (max_time(s, lo, size / 2) > max_time(s, lo + size / 2, size / 2)) lo += size / 2;
      size = size / 2;
    end
    return lo;
  endfunction

  task automatic do_req(input logic [1:0] cmd, input logic [31:0] addr, input logic shared);
    int          s, hw, way, fin, n, cyc, nops, d;
    logic [11:0] tag;
    logic [31:0] la;
    logic        exp_hit, is_cpu, done;
    s   = int'(addr[19:6]);
    tag = addr[31:20];
    la  = {addr[31:6], 6'b0};
    hw  = -1;
    for (int w = 0; w < 16; w++) if (m_mesi[s][w] != ST_I && m_tag[s][w] == tag) hw = w;
    exp_hit = (hw >= 0);
    is_cpu  = (cmd == C_RD || cmd == C_WR);
    e_op.delete();
    e_addr.delete();
    way = exp_hit ? hw : 0;
    fin = ST_I;
    if (is_cpu && !exp_hit) begin
      way = model_victim(s);
      if (m_mesi[s][way] == ST_M) begin
        e_op.push_back(OP_WB);
        e_addr.push_back({m_tag[s][way], addr[19:6], 6'b0});
      end
      e_op.push_back(cmd == C_RD ? OP_READ : OP_RWIM);
      e_addr.push_back(la);
      fin = (cmd == C_WR) ? ST_M : (shared ? ST_S : ST_E);
    end else if (is_cpu) begin
      fin = m_mesi[s][way];
      if (cmd == C_WR) begin
        if (fin == ST_S) begin
          e_op.push_back(OP_INVAL);
          e_addr.push_back(la);
        end
        fin = ST_M;
      end
    end else if (exp_hit) begin
      if (m_mesi[s][way] == ST_M) begin
        e_op.push_back(OP_WB);
        e_addr.push_back(la);
      end
      fin = (cmd == C_SRD) ? ST_S : ST_I;
    end

    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc  = 0;
    nops = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_valid) begin
        if (nops < e_op.size()) begin
          check("bus_op", {30'd0, bus_op}, {30'd0, e_op[nops]});
          check("bus_addr", bus_addr, e_addr[nops]);
        end else begin
          check("bus_extra", nops, e_op.size());
        end
        nops++;
        d = $urandom_range(0, 2);
        if (d > 0) begin
          repeat (d) @(negedge clk);
          check("bus_hold", {31'd0, bus_valid}, 32'd1);
        end
        bus_ack    = 1'b1;
        bus_shared = shared;
        @(posedge clk);
        #1;
        bus_ack    = 1'b0;
        bus_shared = 1'b0;
      end else if (resp_valid) begin
        done = 1'b1;
        check("resp_hit", {31'd0, resp_hit}, {31'd0, exp_hit});
        if (is_cpu || exp_hit) begin
          check("resp_way", {28'd0, resp_way}, way);
          check("resp_mesi", {30'd0, resp_mesi}, fin);
        end
      end
    end
    check("resp_seen", {31'd0, done}, 32'd1);
    check("bus_count", nops, e_op.size());
    if (e_op.size() == 0) check("latency", cyc, 2);
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);

    if (is_cpu || exp_hit) begin
      m_mesi[s][way] = fin;
      m_tag[s][way]  = tag;
    end
    if (is_cpu) begin
      now_t++;
      m_time[s][way] = now_t;
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  c;
    logic [31:0] a;
    model_reset();

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    check("rst_resp_way", {28'd0, resp_way}, 32'd0);
    check("rst_resp_mesi", {30'd0, resp_mesi}, 32'd0);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_bus_op", {30'd0, bus_op}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    do_req(C_RD, 32'h0000_0040, 1'b0);
    do_req(C_RD, 32'h0000_0040, 1'b0);
    do_req(C_WR, 32'h0000_0040, 1'b0);
    do_req(C_RD, 32'h0000_0080, 1'b1);
    do_req(C_WR, 32'h0000_0080, 1'b0);

    for (int k = 0; k < 16; k++)
      do_req(($urandom_range(0, 1) != 0) ? C_WR : C_RD, 32'h0000_0040 + k * 32'h0010_0000,
             1'($urandom_range(0, 1)));
    for (int k = 16; k < 21; k++)
      do_req(($urandom_range(0, 1) != 0) ? C_WR : C_RD, 32'h0000_0040 + k * 32'h0010_0000,
             1'($urandom_range(0, 1)));

    do_req(C_SRD, 32'h0000_0080, 1'b0);
    do_req(C_SRD, 32'h0000_0040 + 18 * 32'h0010_0000, 1'b0);
    do_req(C_RD, 32'h0000_0040 + 21 * 32'h0010_0000, 1'b0);
    do_req(C_RD, 32'h0000_00C0, 1'b0);
    do_req(C_SINV, 32'h0000_00C0, 1'b0);
    do_req(C_SRD, 32'h1000_00C0, 1'b0);
    do_req(C_SINV, 32'h2000_00C0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      c = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      a = {12'($urandom_range(0, 19)), 14'($urandom_range(4, 7)), 6'($urandom_range(0, 63))};
      do_req(c, a, 1'($urandom_range(0, 1)));
    end

    req_valid = 1'b1;
    req_cmd   = C_RD;
    req_addr  = 32'h0050_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_valid && n < 20);
    check("midop_bus_valid", {31'd0, bus_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midop_drop", {31'd0, bus_valid}, 32'd0);
    check("midop_ready", {31'd0, req_ready}, 32'd0);
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    do_req(C_RD, 32'h0050_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
